fifo_sync_flex: RTL
===================

# fifo_sync_flex

Single-clock, parametrised FIFO buffer with programmable almost-full/almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags, and a selectable standard or first-word-fall-through (FWFT) read mode. It serves same-domain buffering needs across the design, such as staging write data ahead of the async FIFO or decoupling producer/consumer stages inside one clock domain. Storage is a register array, so there are no RAM macros.

## Interface
- DATA_SIZE, 8, data word width in bits
- ADDR_SIZE, 4, pointer width; depth DEPTH = 2**ADDR_SIZE (power of two only)
- AFULL_THRESH, 12, almost_full asserts when count >= this value
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- Legal range: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH, with AFULL_THRESH >= 1

Ports:
- clk  in  1  clock; all logic is posedge
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_SIZE  write word
- rd_en  in  1  read request (FWFT: pop/acknowledge the head word)
- rd_data  out  DATA_SIZE  read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_SIZE+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Write acceptance: wr_acc = wr_en & ~full. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty. On acceptance, rd_ptr increments.
- Full and empty are strict. There is no write-through-on-read at full and no bypass at empty.
- Pointers are ADDR_SIZE bits wide and wrap DEPTH-1 -> 0 naturally. There is no extra wrap bit, because full/empty are derived from count.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
  - count never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are registered. Each is computed from the next value of count, so all four change on the same edge as count.
- Standard mode (FWFT=0): rd_data is a register. It loads mem[rd_ptr] on rd_acc and holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] combinationally while ~empty, and 0 while empty. rd_en consumes the presented word.
- overflow is set on wr_en & full. underflow is set on rd_en & empty. Both are cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Memory contents are not reset. Reset returns the pointers to 0, which logically empties the FIFO.
- Reset values:
  - count = 0, empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - overflow = 0, underflow = 0
  - rd_data = 0
  - wr_ptr = rd_ptr = 0
- Reset asserted mid-operation discards all stored words immediately (asynchronously). The first write after rst deasserts lands at address 0.

## Timing
- A write accepted at edge N appears in count/empty/almost_* after edge N.
- Standard mode: the earliest read of that word is rd_en high in cycle N+1, with rd_data valid after edge N+1. Write-to-data latency is 2 edges; read latency is 1 edge from rd_en.
- FWFT mode: the written word is on rd_data right after edge N (write-to-data latency 1 edge). After a pop at edge M, the next word is on rd_data right after edge M.
- Simultaneous wr_en & rd_en:
  - when empty: write accepted, read rejected, underflow set, count -> 1
  - when full: read accepted, write rejected, overflow set, count -> DEPTH-1
  - otherwise: both accepted, count unchanged, flags unchanged.
- All outputs except FWFT rd_data are registered. FWFT rd_data is combinational from registers only; there is no input-to-output combinational path.

## Test plan
- Fill/drain (defaults, FWFT=0): write 0x01..0x10 on 16 consecutive cycles -> full=1 and almost_full=1 after the 16th edge (almost_full first rises after the 12th write), count=16. Then read 16 -> rd_data sequence 0x01..0x10 with 1-edge latency; almost_empty rises when count=4; empty=1 at the end.
- Overflow/underflow: write at full -> data unchanged, count=16, overflow=1 and it stays set. Pulse clr_err -> overflow=0. Read while empty -> underflow=1 and rd_data holds its last value. clr_err together with a fresh violation -> flag stays 1.
- Simultaneous: at count=5, wr_en+rd_en for 20 cycles -> count stays 5, pointers wrap past 15, data order preserved. At empty, wr+rd -> count=1, underflow=1. At full, wr+rd -> count=15, overflow=1.
- FWFT=1: write 0xA5 at edge N -> rd_data=0xA5 and empty=0 after edge N. Pop -> rd_data=0 and empty=1. Queue 0x11, 0x22 -> 0x11 presented first, then 0x22 the cycle after the pop.
- Reset mid-operation: hold count=9, assert rst between edges -> count=0, empty=1, rd_data=0 immediately. Release rst, then write 0x3C and read -> 0x3C is returned (address 0).
- Threshold parameters AFULL_THRESH=3, AEMPTY_THRESH=0, ADDR_SIZE=2: almost_full rises at count=3; almost_empty is high only at count=0; full at count=4.

Source files
------------

// File: rtl/fifo_sync_flex.sv
// -----------------------------------------------------------------------------
// fifo_sync_flex
//
// Single-clock FIFO built on a register array. It provides programmable
// almost-full/almost-empty thresholds, a fill-level count, and sticky
// overflow/underflow flags. The read mode is selectable: a standard registered
// read, or first-word-fall-through (FWFT).
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst           in   asynchronous, active-high reset
//   wr_en         in   write request
//   wr_data       in   write word (DATA_SIZE)
//   rd_en         in   read request (FWFT: pop the presented head word)
//   rd_data       out  read word (DATA_SIZE)
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AFULL_THRESH
//   almost_empty  out  count <= AEMPTY_THRESH
//   count         out  stored words, 0..DEPTH (ADDR_SIZE+1 bits)
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
//   clr_err       in   synchronous clear of overflow/underflow
//
// Handshake: a write transfers on any edge where wr_en=1 and full=0. A read
// transfers on any edge where rd_en=1 and empty=0. A request made against a
// full/empty FIFO is dropped and recorded in the matching sticky flag. The
// requester may hold or drop its request freely; nothing is queued.
// -----------------------------------------------------------------------------
module fifo_sync_flex #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int CW    = ADDR_SIZE + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THRESH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [CW-1:0]        count_nxt;
    logic                 wr_acc;
    logic                 rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Full and empty come from count, so the pointers carry no wrap bit.
    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately not reset. Clearing the pointers empties the FIFO logically.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            // Flags are derived from count_nxt so they move on the same edge as count.
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            // When a new violation and clr_err arrive together, the set wins.
            overflow     <= (overflow  & ~clr_err) | (wr_en & full);
            underflow    <= (underflow & ~clr_err) | (rd_en & empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is presented combinationally from registers only.
            // It is forced to 0 while empty, so stale storage never leaks out.
            assign rd_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_SIZE-1:0] rd_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_ptr];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule
